// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared store/load size and FSM encodings
// Purpose: access-size encodings used by both the store and load paths,
//          the store FSM state encoding, and small strobe helpers.
// Ports:   none (package).
package store_pkg;

  // Access size carried on store_select / load size fields.
  typedef enum logic [2:0] {
    MEM_SIZE_BYTE = 3'b000,
    MEM_SIZE_HALF = 3'b001,
    MEM_SIZE_WORD = 3'b010
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_FAULT = 2'd3
  } store_state_e;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == MEM_SIZE_BYTE) || (size == MEM_SIZE_HALF) || (size == MEM_SIZE_WORD);
  endfunction

  // Unshifted lane mask for an access at byte offset 0; zero for illegal codes.
  function automatic logic [3:0] base_strobe(input logic [2:0] size);
    logic [3:0] strb;
    case (size)
      MEM_SIZE_BYTE: strb = 4'b0001;
      MEM_SIZE_HALF: strb = 4'b0011;
      MEM_SIZE_WORD: strb = 4'b1111;
      default:       strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // True when the access spills past the end of its 32-bit word.
  function automatic logic crosses_word(input logic [2:0] size, input logic [1:0] offset);
    logic [7:0] strb;
    strb = {4'b0000, base_strobe(size)} << offset;
    return strb[7:4] != 4'b0000;
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// rtl/store_lane_shifter.sv - combinational store data/strobe lane shifter
// Purpose: moves right-justified store data and its byte mask to the lanes
//          selected by the byte offset, over a two-word window.
// Ports:   data    - right-justified store data
//          offset  - byte offset within the word (addr[1:0])
//          size    - access size code
//          shifted - two-word shifted data (low word = first beat)
//          strobe  - two-word byte mask (low nibble = first beat)
module store_lane_shifter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [1:0]              offset,
  input  logic [2:0]              size,
  output logic [2*DATA_WIDTH-1:0] shifted,
  output logic [7:0]              strobe
);
  import store_pkg::*;

  assign shifted = {{DATA_WIDTH{1'b0}}, data} << {offset, 3'b000};
  assign strobe  = {4'b0000, base_strobe(size)} << offset;

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store alignment FSM issuing one or two memory write beats
// Purpose: accepts a store, aligns data/strobes to byte lanes and writes one
//          beat, or two beats when the store crosses a word boundary and
//          STORE_MISALIGN_SPLIT_EN is defined (otherwise such stores fault).
// Ports:   clk, rst_n                 - clock, synchronous active-low reset
//          req_valid/req_ready        - store request handshake
//          req_addr/req_data          - store byte address, right-justified data
//          store_select               - access size code
//          mem_wr_valid/mem_wr_ready  - memory write beat handshake
//          mem_wr_addr/data/strb      - word-aligned beat address, lane data, byte enables
//          done                       - one-cycle pulse after the last beat completes
//          misalign_fault             - one-cycle pulse for a rejected store
module store_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            store_select,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]            mem_wr_strb,
  output logic                  done,
  output logic                  misalign_fault
);
  import store_pkg::*;

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  store_state_e state, state_nx;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [2:0]              size_q;
  logic                    done_q;
  logic                    last_beat;
  logic                    reject;
  logic                    split;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [2*DATA_WIDTH-1:0] shifted;
  logic [7:0]              strobe;

  store_lane_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .data    (data_q),
    .offset  (addr_q[1:0]),
    .size    (size_q),
    .shifted (shifted),
    .strobe  (strobe)
  );

  // Decided on the live request so a rejected store never reaches BEAT0.
  assign reject    = !size_legal(store_select) ||
                     (!SplitEn && crosses_word(store_select, req_addr[1:0]));
  assign split     = SplitEn && (strobe[7:4] != 4'b0000);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= 3'b000;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_beat;
      if (state == ST_IDLE && req_valid) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= store_select;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    mem_wr_valid   = 1'b0;
    mem_wr_addr    = '0;
    mem_wr_data    = '0;
    mem_wr_strb    = 4'b0000;
    misalign_fault = 1'b0;
    last_beat      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = reject ? ST_FAULT : ST_BEAT0;
      end
      ST_BEAT0: begin
        mem_wr_valid = 1'b1;
        mem_wr_addr  = word_addr;
        mem_wr_data  = shifted[DATA_WIDTH-1:0];
        mem_wr_strb  = strobe[3:0];
        if (mem_wr_ready) begin
          if (split) begin
            state_nx = ST_BEAT1;
          end else begin
            state_nx  = ST_IDLE;
            last_beat = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        // Address wraps modulo 2^ADDR_WIDTH past the top word.
        mem_wr_valid = 1'b1;
        mem_wr_addr  = word_addr + ADDR_WIDTH'(4);
        mem_wr_data  = shifted[2*DATA_WIDTH-1:DATA_WIDTH];
        mem_wr_strb  = strobe[7:4];
        if (mem_wr_ready) begin
          state_nx  = ST_IDLE;
          last_beat = 1'b1;
        end
      end
      ST_FAULT: begin
        misalign_fault = 1'b1;
        state_nx       = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - self-checking bench for store_align_unit
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  store_select;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        done;
  logic        misalign_fault;

  always #5 clk = ~clk;

  store_align_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .store_select   (store_select),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_ready   (mem_wr_ready),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_strb    (mem_wr_strb),
    .done           (done),
    .misalign_fault (misalign_fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
    int          stall;
    int          nbeats;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  vec_t  vecs[10];
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sel,
                              input int stall, input int nbeats,
                              input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    vec_t v;
    v.addr = addr; v.data = data; v.sel = sel; v.stall = stall; v.nbeats = nbeats;
    v.a0 = a0; v.d0 = d0; v.s0 = s0; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         fault_cnt = 0;
    int         fault_cyc = -1;
    logic       prev_stall = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    logic [3:0]  ps = '0;
    beat_t      b;
    @(negedge clk);
    chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_addr     = v.addr;
    req_data     = v.data;
    store_select = v.sel;
    if (v.nbeats >= 1) begin b.addr = v.a0; b.data = v.d0; b.strb = v.s0; exp_q.push_back(b); end
    if (v.nbeats >= 2) begin b.addr = v.a1; b.data = v.d1; b.strb = v.s1; exp_q.push_back(b); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      mem_wr_ready = (k > v.stall);
      if (prev_stall && mem_wr_valid) begin
        chk("held_addr", mem_wr_addr, pa);
        chk("held_data", mem_wr_data, pd);
        chk("held_strb", {28'b0, mem_wr_strb}, {28'b0, ps});
      end
      if (mem_wr_valid) begin
        if (mem_wr_ready) begin
          prev_stall = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {31'b0, mem_wr_valid}, 32'd0);
          end else begin
            b = exp_q.pop_front();
            chk("beat_addr", mem_wr_addr, b.addr);
            chk("beat_data", mem_wr_data, b.data);
            chk("beat_strb", {28'b0, mem_wr_strb}, {28'b0, b.strb});
          end
        end else begin
          prev_stall = 1'b1;
          pa = mem_wr_addr;
          pd = mem_wr_data;
          ps = mem_wr_strb;
        end
      end else begin
        prev_stall = 1'b0;
        chk("idle_data_zero", mem_wr_data, 32'd0);
        chk("idle_strb_zero", {28'b0, mem_wr_strb}, 32'd0);
      end
      if (done) begin done_cnt++; done_cyc = k; end
      if (misalign_fault) begin fault_cnt++; fault_cyc = k; end
      @(negedge clk);
    end
    chk("beats_outstanding", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("done_count", done_cnt, (v.nbeats > 0) ? 32'd1 : 32'd0);
    chk("fault_count", fault_cnt, (v.nbeats == 0) ? 32'd1 : 32'd0);
    if (v.nbeats > 0) chk("done_latency", done_cyc, v.nbeats + 1 + v.stall);
    else              chk("fault_latency", fault_cyc, 32'd1);
    chk("req_ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_valid"}, {31'b0, mem_wr_valid}, 32'd0);
    chk({tag, "_addr"}, mem_wr_addr, 32'd0);
    chk({tag, "_data"}, mem_wr_data, 32'd0);
    chk({tag, "_strb"}, {28'b0, mem_wr_strb}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_fault"}, {31'b0, misalign_fault}, 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_data     = '0;
    store_select = 3'b000;
    mem_wr_ready = 1'b0;

    vecs[0] = mk(32'h100, 32'hDEADBEEF, 3'b010, 0, 1, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
    vecs[1] = mk(32'h103, 32'h000000A5, 3'b000, 0, 1, 32'h100, 32'hA5000000, 4'b1000, 0, 0, 0);
    vecs[5] = mk(32'h400, 32'h55667788, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(32'h102, 32'h0000BEEF, 3'b001, 1, 1, 32'h100, 32'hBEEF0000, 4'b1100, 0, 0, 0);
    vecs[7] = mk(32'h001, 32'h0000007F, 3'b000, 0, 1, 32'h000, 32'h00007F00, 4'b0010, 0, 0, 0);
    vecs[8] = mk(32'h500, 32'h01020304, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9] = mk(32'h101, 32'h0000ABCD, 3'b001, 0, 1, 32'h100, 32'h00ABCD00, 4'b0110, 0, 0, 0);
`ifdef STORE_MISALIGN_SPLIT_EN
    vecs[2] = mk(32'h203, 32'h00001234, 3'b001, 0, 2, 32'h200, 32'h34000000, 4'b1000,
                 32'h204, 32'h00000012, 4'b0001);
    vecs[3] = mk(32'hFFFFFFFE, 32'hCAFEF00D, 3'b010, 3, 2, 32'hFFFFFFFC, 32'hF00D0000, 4'b1100,
                 32'h00000000, 32'h0000CAFE, 4'b0011);
    vecs[4] = mk(32'h301, 32'h11223344, 3'b010, 0, 2, 32'h300, 32'h22334400, 4'b1110,
                 32'h304, 32'h00000011, 4'b0001);
`else
    vecs[2] = mk(32'h203, 32'h00001234, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(32'hFFFFFFFE, 32'hCAFEF00D, 3'b010, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(32'h301, 32'h11223344, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while a beat is stalled: in-flight store dropped, no done afterwards.
    @(negedge clk);
    req_valid    = 1'b1;
    mem_wr_ready = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    req_addr     = 32'h203;
    req_data     = 32'h00001234;
    store_select = 3'b001;
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    mem_wr_ready = 1'b1;
    @(negedge clk);
    mem_wr_ready = 1'b0;
    chk("stall_beat1_addr", mem_wr_addr, 32'h204);
`else
    req_addr     = 32'h100;
    req_data     = 32'h12345678;
    store_select = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    @(negedge clk);
    chk("stall_beat0_addr", mem_wr_addr, 32'h100);
`endif
    chk("stall_valid", {31'b0, mem_wr_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n        = 1'b1;
    mem_wr_ready = 1'b1;
    done_seen    = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || mem_wr_valid) done_seen++;
    end
    chk("no_activity_after_reset", done_seen, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
